// File: rtl/alu_exec_stage_pkg.sv
// Shared definitions for the ALU execute stage: control codes, FSM states, flag payload.
package alu_exec_stage_pkg;

  localparam int unsigned CTRL_W = 3;

  localparam logic [CTRL_W-1:0] ALU_ADD = 3'b000;
  localparam logic [CTRL_W-1:0] ALU_SUB = 3'b001;
  localparam logic [CTRL_W-1:0] ALU_AND = 3'b010;
  localparam logic [CTRL_W-1:0] ALU_OR  = 3'b011;
  localparam logic [CTRL_W-1:0] ALU_SLT = 3'b101;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  typedef struct packed {
    logic zero;
    logic negative;
    logic carry;
    logic overflow;
  } alu_flags_t;

endpackage

// File: rtl/alu_exec_stage_core.sv
// Combinational ALU: (control, a, b) -> result, flags and a reserved-code indication.
module alu_exec_stage_core
  import alu_exec_stage_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [CTRL_W-1:0] i_alu_control,
  input  logic [WIDTH-1:0]  i_a,
  input  logic [WIDTH-1:0]  i_b,
  output logic [WIDTH-1:0]  o_result_c,
  output alu_flags_t        o_flags_c,
  output logic              o_illegal_c
);

  localparam int unsigned MSB = WIDTH - 1;
  localparam int unsigned XW  = WIDTH + 1;

  logic [WIDTH:0] w_sum;
  logic [WIDTH:0] w_diff;
  logic           w_add_ovf;
  logic           w_sub_ovf;
  logic           w_slt;

  // Subtraction as a + ~b + 1 so the carry-out means "no borrow".
  assign w_sum     = {1'b0, i_a} + {1'b0, i_b};
  assign w_diff    = {1'b0, i_a} + {1'b0, ~i_b} + XW'(1);
  assign w_add_ovf = (i_a[MSB] == i_b[MSB]) & (w_sum[MSB] != i_a[MSB]);
  assign w_sub_ovf = (i_a[MSB] != i_b[MSB]) & (w_diff[MSB] != i_a[MSB]);
  assign w_slt     = w_diff[MSB] ^ w_sub_ovf;

  always_comb begin
    o_result_c  = '0;
    o_flags_c   = '0;
    o_illegal_c = 1'b0;
    case (i_alu_control)
      ALU_ADD: begin
        o_result_c         = w_sum[MSB:0];
        o_flags_c.carry    = w_sum[WIDTH];
        o_flags_c.overflow = w_add_ovf;
      end
      ALU_SUB: begin
        o_result_c         = w_diff[MSB:0];
        o_flags_c.carry    = w_diff[WIDTH];
        o_flags_c.overflow = w_sub_ovf;
      end
      ALU_AND: o_result_c = i_a & i_b;
      ALU_OR:  o_result_c = i_a | i_b;
      ALU_SLT: o_result_c = WIDTH'(w_slt);
      default: o_illegal_c = 1'b1;
    endcase
    o_flags_c.zero     = (o_result_c == '0);
    o_flags_c.negative = o_result_c[MSB];
  end

endmodule

// File: rtl/alu_exec_stage.sv
// Execute stage: valid/ready input, ALU computed on accept, output reg plus skid reg
// so a full-rate stream survives one cycle of downstream backpressure.
module alu_exec_stage
  import alu_exec_stage_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] alu_control,
  input  logic [WIDTH-1:0]  src_a,
  input  logic [WIDTH-1:0]  src_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  result,
  output logic              zero,
  output logic              negative,
  output logic              carry,
  output logic              overflow,
  output logic              illegal_op
);

  state_t           r_state;
  state_t           w_next_state;
  logic             r_in_ready;
  logic             r_out_valid;
  logic             r_illegal;
  logic [WIDTH-1:0] r_out_result;
  logic [WIDTH-1:0] r_skid_result;
  alu_flags_t       r_out_flags;
  alu_flags_t       r_skid_flags;

  logic [WIDTH-1:0] w_core_result;
  alu_flags_t       w_core_flags;
  logic             w_core_illegal;
  logic             w_accept;
  logic             w_drain;
  logic             w_load_out_in;
  logic             w_load_out_skid;
  logic             w_load_skid;

  alu_exec_stage_core #(.WIDTH(WIDTH)) u_core (
    .i_alu_control (alu_control),
    .i_a           (src_a),
    .i_b           (src_b),
    .o_result_c    (w_core_result),
    .o_flags_c     (w_core_flags),
    .o_illegal_c   (w_core_illegal)
  );

  assign w_accept = in_valid & r_in_ready;
  assign w_drain  = r_out_valid & out_ready;

  // State register; in_ready/out_valid are registered from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_EMPTY;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_in_ready  <= (w_next_state != ST_TWO);
      r_out_valid <= (w_next_state != ST_EMPTY);
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_EMPTY: if (w_accept) w_next_state = ST_ONE;
      ST_ONE: begin
        if (w_accept && !w_drain)      w_next_state = ST_TWO;
        else if (!w_accept && w_drain) w_next_state = ST_EMPTY;
      end
      ST_TWO:   if (w_drain) w_next_state = ST_ONE;
      default:  w_next_state = ST_EMPTY;
    endcase
  end

  always_comb begin
    w_load_out_in   = 1'b0;
    w_load_out_skid = 1'b0;
    w_load_skid     = 1'b0;
    case (r_state)
      ST_EMPTY: w_load_out_in = w_accept;
      ST_ONE: begin
        w_load_out_in = w_accept & w_drain;
        w_load_skid   = w_accept & ~w_drain;
      end
      ST_TWO:   w_load_out_skid = w_drain;
      default: ;
    endcase
  end

  // Payload registers and sticky reserved-code flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_result  <= '0;
      r_out_flags   <= '0;
      r_skid_result <= '0;
      r_skid_flags  <= '0;
      r_illegal     <= 1'b0;
    end else begin
      if (w_load_out_in) begin
        r_out_result <= w_core_result;
        r_out_flags  <= w_core_flags;
      end else if (w_load_out_skid) begin
        r_out_result <= r_skid_result;
        r_out_flags  <= r_skid_flags;
      end
      if (w_load_skid) begin
        r_skid_result <= w_core_result;
        r_skid_flags  <= w_core_flags;
      end
      if (w_accept && w_core_illegal) r_illegal <= 1'b1;
    end
  end

  assign in_ready   = r_in_ready;
  assign out_valid  = r_out_valid;
  assign result     = r_out_result;
  assign zero       = r_out_flags.zero;
  assign negative   = r_out_flags.negative;
  assign carry      = r_out_flags.carry;
  assign overflow   = r_out_flags.overflow;
  assign illegal_op = r_illegal;

endmodule

// File: tb/tb_alu_exec_stage.sv
// Directed self-checking bench for alu_exec_stage.
module tb_alu_exec_stage;
  import alu_exec_stage_pkg::*;

  localparam int unsigned WIDTH = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [CTRL_W-1:0] alu_control;
  logic [WIDTH-1:0]  src_a;
  logic [WIDTH-1:0]  src_b;
  logic              out_valid;
  logic              out_ready;
  logic [WIDTH-1:0]  result;
  logic              zero;
  logic              negative;
  logic              carry;
  logic              overflow;
  logic              illegal_op;

  int n_vec = 0;
  int n_err = 0;

  alu_exec_stage #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .alu_control (alu_control),
    .src_a       (src_a),
    .src_b       (src_b),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .result      (result),
    .zero        (zero),
    .negative    (negative),
    .carry       (carry),
    .overflow    (overflow),
    .illegal_op  (illegal_op)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Single op through an empty or draining stage with out_ready=1.
  task automatic op_check(input string tag, input logic [2:0] ctrl,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_res, input logic exp_c, input logic exp_v);
    alu_control = ctrl;
    src_a       = a;
    src_b       = b;
    in_valid    = 1'b1;
    step();
    in_valid = 1'b0;
    chk({tag, ".valid"}, 32'(out_valid), 32'd1);
    chk({tag, ".result"}, result, exp_res);
    chk({tag, ".zero"}, 32'(zero), 32'(exp_res == 32'd0));
    chk({tag, ".neg"}, 32'(negative), 32'(exp_res[31]));
    chk({tag, ".carry"}, 32'(carry), 32'(exp_c));
    chk({tag, ".ovf"}, 32'(overflow), 32'(exp_v));
  endtask

  initial begin
    rst         = 1'b1;
    in_valid    = 1'b0;
    out_ready   = 1'b0;
    alu_control = ALU_ADD;
    src_a       = '0;
    src_b       = '0;
    step();
    step();
    chk("rst.in_ready", 32'(in_ready), 32'd0);
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk("rst.result", result, 32'd0);
    chk("rst.zero", 32'(zero), 32'd0);
    chk("rst.illegal", 32'(illegal_op), 32'd0);
    rst = 1'b0;
    step();
    chk("post_rst.in_ready", 32'(in_ready), 32'd1);
    chk("post_rst.out_valid", 32'(out_valid), 32'd0);

    // Arithmetic and logic corner cases
    out_ready = 1'b1;
    op_check("add_ovf",    ALU_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b1);
    op_check("sub_eq",     ALU_SUB, 32'd5,         32'd5,         32'h0000_0000, 1'b1, 1'b0);
    op_check("slt_neg",    ALU_SLT, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0);
    op_check("slt_pos",    ALU_SLT, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b0);
    op_check("sub_borrow", ALU_SUB, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1'b0);
    op_check("add_wrap",   ALU_ADD, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0);
    op_check("sub_ovf",    ALU_SUB, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b1, 1'b1);
    op_check("and",        ALU_AND, 32'hA5A5_0F0F, 32'h0FF0_FFFF, 32'h05A0_0F0F, 1'b0, 1'b0);
    op_check("or",         ALU_OR,  32'hA5A5_0F0F, 32'h0FF0_FFFF, 32'hAFF5_FFFF, 1'b0, 1'b0);
    step();
    chk("drain.out_valid", 32'(out_valid), 32'd0);

    // Backpressure: A, B fill the stage, C waits, then drain in order
    out_ready   = 1'b0;
    alu_control = ALU_ADD;
    in_valid    = 1'b1;
    src_a = 32'h1;   src_b = 32'h2;
    step();
    chk("bp.a.in_ready", 32'(in_ready), 32'd1);
    chk("bp.a.result", result, 32'h3);
    src_a = 32'h10;  src_b = 32'h20;
    step();
    chk("bp.b.in_ready", 32'(in_ready), 32'd0);
    chk("bp.b.result", result, 32'h3);
    src_a = 32'h100; src_b = 32'h200;
    step();
    chk("bp.c.in_ready", 32'(in_ready), 32'd0);
    chk("bp.c.out_valid", 32'(out_valid), 32'd1);
    chk("bp.c.stable", result, 32'h3);
    out_ready = 1'b1;
    step();
    chk("bp.b_out.result", result, 32'h30);
    chk("bp.b_out.in_ready", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    chk("bp.c_out.result", result, 32'h300);
    chk("bp.c_out.valid", 32'(out_valid), 32'd1);
    step();
    chk("bp.empty", 32'(out_valid), 32'd0);

    // Full-rate stream of 10 ops
    alu_control = ALU_ADD;
    for (int i = 0; i < 10; i++) begin
      src_a    = 32'(i);
      src_b    = 32'(3 * i);
      in_valid = 1'b1;
      step();
      chk($sformatf("stream%0d.in_ready", i), 32'(in_ready), 32'd1);
      chk($sformatf("stream%0d.valid", i), 32'(out_valid), 32'd1);
      chk($sformatf("stream%0d.result", i), result, 32'(4 * i));
    end
    in_valid = 1'b0;
    step();
    chk("stream.end", 32'(out_valid), 32'd0);

    // Reserved code: zero result, sticky illegal flag
    op_check("resv", 3'b110, 32'h1234, 32'h5678, 32'h0, 1'b0, 1'b0);
    chk("resv.illegal", 32'(illegal_op), 32'd1);
    op_check("after_resv", ALU_ADD, 32'd1, 32'd1, 32'd2, 1'b0, 1'b0);
    chk("after_resv.illegal", 32'(illegal_op), 32'd1);
    step();

    // Reset while full: old contents must never reappear
    out_ready   = 1'b0;
    alu_control = ALU_ADD;
    in_valid    = 1'b1;
    src_a = 32'hAA; src_b = 32'h0;
    step();
    src_a = 32'hBB; src_b = 32'h0;
    step();
    in_valid = 1'b0;
    chk("full.in_ready", 32'(in_ready), 32'd0);
    chk("full.result", result, 32'hAA);
    rst = 1'b1;
    step();
    chk("mid_rst.out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst.in_ready", 32'(in_ready), 32'd0);
    chk("mid_rst.illegal", 32'(illegal_op), 32'd0);
    chk("mid_rst.result", result, 32'd0);
    rst       = 1'b0;
    out_ready = 1'b1;
    step();
    chk("rel_rst.in_ready", 32'(in_ready), 32'd1);
    chk("rel_rst.out_valid", 32'(out_valid), 32'd0);
    step();
    chk("rel_rst.no_stale", 32'(out_valid), 32'd0);
    op_check("post_rst_op", ALU_ADD, 32'd3, 32'd4, 32'd7, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
